// File: rtl/sum_accumulator_if.sv
// Upstream sample/backpressure and downstream window handshake for sum_accumulator.
// The master side feeds samples and accepts windows; the slave side is the accumulator.
interface sum_accumulator_if #(
   parameter int unsigned ACC_W = 12
) ();
   logic             en;
   logic [8:0]       sum;
   logic             stall;
   logic [ACC_W-1:0] acc_out;
   logic             acc_valid;
   logic             acc_ready;
   logic             ovf;
   logic [7:0]       count;

   modport master (
      output en, sum, acc_ready,
      input  stall, acc_out, acc_valid, ovf, count
   );

   modport slave (
      input  en, sum, acc_ready,
      output stall, acc_out, acc_valid, ovf, count
   );
endinterface

// File: rtl/sum_accumulator.sv
// Windowed saturating accumulator of 9-bit adder results; a full window is held
// with acc_valid until the downstream side accepts it, stalling upstream meanwhile.
module sum_accumulator #(
   parameter int unsigned WIN   = 4,
   parameter int unsigned ACC_W = 12
) (
   input logic           clk,
   input logic           rst,
   sum_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [7:0]       cnt, cnt_n;
   logic             ovf_r, ovf_n;

   logic             stall;
   logic             accept;
   logic             xfer;
   logic [ACC_W-1:0] base_acc;
   logic [7:0]       base_cnt;
   logic             base_ovf;
   logic [ACC_W:0]   sum_w;

   assign stall  = (state == HOLD) && !bus.acc_ready;
   assign accept = bus.en && !stall;
   assign xfer   = (state == HOLD) && bus.acc_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf_r <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         ovf_r <= ovf_n;
      end
   end

   // A transfer and an accept may share an edge: the new sample then starts a fresh window.
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      cnt_n    = cnt;
      ovf_n    = ovf_r;
      base_acc = xfer ? '0 : acc;
      base_cnt = xfer ? '0 : cnt;
      base_ovf = xfer ? 1'b0 : ovf_r;
      sum_w    = {1'b0, base_acc} + {{(ACC_W - 8){1'b0}}, bus.sum};

      if (accept) begin
         if (sum_w[ACC_W]) begin
            acc_n = '1;
            ovf_n = 1'b1;
         end else begin
            acc_n = sum_w[ACC_W-1:0];
            ovf_n = base_ovf;
         end
         cnt_n   = base_cnt + 8'd1;
         state_n = (cnt_n == 8'(WIN)) ? HOLD : ACCUM;
      end else if (xfer) begin
         acc_n   = '0;
         cnt_n   = '0;
         ovf_n   = 1'b0;
         state_n = IDLE;
      end
   end

   assign bus.stall     = stall;
   assign bus.acc_out   = acc;
   assign bus.acc_valid = (state == HOLD);
   assign bus.ovf       = ovf_r;
   assign bus.count     = cnt;

endmodule
